// File: rtl/trdb_enc_ctrl.sv
// Trace encoder control: enable/disable sequencing, single-shot event flags for the
// packet-format selection logic, and the resync timer feeding its timeout inputs.
module trdb_enc_ctrl #(
  parameter int RCNT_W   = 16,
  parameter int OPMODE_W = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid_i,
  input  logic                trace_enable_i,
  input  logic [OPMODE_W-1:0] opmode_i,
  input  logic                qualified_i,
  input  logic                resync_rst_i,
  input  logic                packet_emitted_i,
  input  logic                resync_mode_i,
  input  logic [RCNT_W-1:0]   resync_max_i,
  output logic                enc_active_o,
  output logic                tc_enc_enabled_o,
  output logic                tc_enc_disabled_o,
  output logic                tc_opmode_change_o,
  output logic                tc_first_qualified_o,
  output logic                lc_final_qualified_o,
  output logic                tc_et_max_resync_o,
  output logic                tc_gt_max_resync_o,
  output logic [RCNT_W-1:0]   resync_cnt_o
);

  typedef enum logic [1:0] {S_OFF, S_STARTING, S_ACTIVE, S_STOPPING} state_t;

  state_t              state_q, state_d;
  logic [OPMODE_W-1:0] opmode_q, opmode_d;
  logic                pend_opm_q, pend_opm_d;
  logic                qual_seen_q, qual_seen_d;
  logic [RCNT_W-1:0]   cnt_q, cnt_d;
  logic [RCNT_W-1:0]   max_w, max_m1_w;
  logic                qual_win, inc;

  assign max_w    = (resync_max_i == '0) ? RCNT_W'(1) : resync_max_i;
  assign max_m1_w = max_w - RCNT_W'(1);
  // Qualification tracking also runs in STOPPING so the last instruction can close out.
  assign qual_win = (state_q == S_ACTIVE) || (state_q == S_STOPPING);
  assign inc      = resync_mode_i ? packet_emitted_i : (valid_i & qualified_i);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OFF:      if (trace_enable_i) state_d = S_STARTING;
      S_STARTING: begin
        if (valid_i)              state_d = S_ACTIVE;
        else if (!trace_enable_i) state_d = S_OFF;
      end
      S_ACTIVE:   if (!trace_enable_i) state_d = S_STOPPING;
      S_STOPPING: if (valid_i) state_d = S_OFF;
      default:    state_d = S_OFF;
    endcase
  end

  always_comb begin
    opmode_d    = opmode_q;
    pend_opm_d  = pend_opm_q & ~valid_i;
    qual_seen_d = qual_seen_q;
    cnt_d       = '0;

    if (state_q == S_ACTIVE) begin
      if (opmode_i != opmode_q) begin
        opmode_d   = opmode_i;
        pend_opm_d = 1'b1;
      end
    end else begin
      opmode_d = opmode_i;
      if (state_q == S_OFF) pend_opm_d = 1'b0;
    end

    if ((state_q == S_OFF) && (state_d == S_STARTING)) qual_seen_d = 1'b0;
    else if (qual_win && valid_i)                      qual_seen_d = qualified_i;

    // Leaving ACTIVE clears the timer; reset request beats a coincident increment.
    if ((state_q == S_ACTIVE) && (state_d == S_ACTIVE)) begin
      cnt_d = cnt_q;
      if (resync_rst_i)             cnt_d = '0;
      else if (inc && cnt_q < max_w) cnt_d = cnt_q + RCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_OFF;
      opmode_q    <= '0;
      pend_opm_q  <= 1'b0;
      qual_seen_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      opmode_q    <= opmode_d;
      pend_opm_q  <= pend_opm_d;
      qual_seen_q <= qual_seen_d;
      cnt_q       <= cnt_d;
    end
  end

  assign enc_active_o         = (state_q == S_ACTIVE);
  assign tc_enc_enabled_o     = (state_q == S_STARTING) & valid_i;
  assign tc_enc_disabled_o    = (state_q == S_STOPPING) & valid_i;
  assign tc_opmode_change_o   = pend_opm_q & valid_i;
  assign tc_first_qualified_o = qual_win & valid_i & qualified_i & ~qual_seen_q;
  assign lc_final_qualified_o = qual_win & valid_i & ~qualified_i & qual_seen_q;
  assign tc_et_max_resync_o   = (cnt_q == max_m1_w) & enc_active_o;
  assign tc_gt_max_resync_o   = (cnt_q >= max_w) & enc_active_o;
  assign resync_cnt_o         = cnt_q;

endmodule

// File: tb/tb_trdb_enc_ctrl.sv
// Scoreboard bench for trdb_enc_ctrl: directed per-cycle vectors with hand-computed
// expected outputs, checked by an independent negedge monitor.
module tb_trdb_enc_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0, trace_enable_i = 1'b0, qualified_i = 1'b0;
  logic        resync_rst_i = 1'b0, packet_emitted_i = 1'b0, resync_mode_i = 1'b0;
  logic [1:0]  opmode_i = 2'd0;
  logic [15:0] resync_max_i = 16'd4;
  logic        enc_active_o, tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o;
  logic        tc_first_qualified_o, lc_final_qualified_o, tc_et_max_resync_o, tc_gt_max_resync_o;
  logic [15:0] resync_cnt_o;

  logic        r_rst = 1'b1, r_mode = 1'b0;
  logic [15:0] r_max = 16'd4;
  logic [23:0] exp_q[$];
  int          nvec = 0, nerr = 0, vidx = 0;

  trdb_enc_ctrl #(.RCNT_W(16), .OPMODE_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .trace_enable_i(trace_enable_i),
    .opmode_i(opmode_i), .qualified_i(qualified_i), .resync_rst_i(resync_rst_i),
    .packet_emitted_i(packet_emitted_i), .resync_mode_i(resync_mode_i),
    .resync_max_i(resync_max_i), .enc_active_o(enc_active_o),
    .tc_enc_enabled_o(tc_enc_enabled_o), .tc_enc_disabled_o(tc_enc_disabled_o),
    .tc_opmode_change_o(tc_opmode_change_o), .tc_first_qualified_o(tc_first_qualified_o),
    .lc_final_qualified_o(lc_final_qualified_o), .tc_et_max_resync_o(tc_et_max_resync_o),
    .tc_gt_max_resync_o(tc_gt_max_resync_o), .resync_cnt_o(resync_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Packed order: active, enabled, disabled, opm, first, final, et, gt, cnt[15:0]
  function automatic logic [23:0] E(input logic act, en, dis, opm, fq, lq, et, gt,
                                    input logic [15:0] cnt);
    return {act, en, dis, opm, fq, lq, et, gt, cnt};
  endfunction

  task automatic drv(input logic v, en, q, rr, pe, input logic [1:0] om,
                     input logic [23:0] exp);
    @(posedge clk_i);
    #1;
    rst_i            = r_rst;
    resync_mode_i    = r_mode;
    resync_max_i     = r_max;
    valid_i          = v;
    trace_enable_i   = en;
    qualified_i      = q;
    resync_rst_i     = rr;
    packet_emitted_i = pe;
    opmode_i         = om;
    exp_q.push_back(exp);
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      logic [23:0] e, got;
      e   = exp_q.pop_front();
      got = {enc_active_o, tc_enc_enabled_o, tc_enc_disabled_o, tc_opmode_change_o,
             tc_first_qualified_o, lc_final_qualified_o, tc_et_max_resync_o,
             tc_gt_max_resync_o, resync_cnt_o};
      nvec++;
      if (got !== e) begin
        nerr++;
        $display("FAIL vec%0d: got act/en/dis/opm/fq/lq/et/gt=%b cnt=%0d, required %b cnt=%0d",
                 vidx, got[23:16], got[15:0], e[23:16], e[15:0]);
      end
      vidx++;
    end
  end

  initial begin
    // Reset and enable with stalls
    drv(0,0,0,0,0,0, E(0,0,0,0,0,0,0,0,0));
    r_rst = 1'b0;
    drv(0,0,0,0,0,0, E(0,0,0,0,0,0,0,0,0));
    drv(0,1,0,0,0,0, E(0,0,0,0,0,0,0,0,0));
    drv(0,1,0,0,0,0, E(0,0,0,0,0,0,0,0,0));
    drv(0,1,0,0,0,0, E(0,0,0,0,0,0,0,0,0));
    drv(0,1,0,0,0,0, E(0,0,0,0,0,0,0,0,0));
    drv(1,1,0,0,0,0, E(0,1,0,0,0,0,0,0,0));
    drv(0,1,0,0,0,0, E(1,0,0,0,0,0,0,0,0));
    // Qualification gaps 0,1,(stall),1,0,1
    drv(1,1,0,0,0,0, E(1,0,0,0,0,0,0,0,0));
    drv(1,1,1,0,0,0, E(1,0,0,0,1,0,0,0,0));
    drv(0,1,0,0,0,0, E(1,0,0,0,0,0,0,0,1));
    drv(1,1,1,0,0,0, E(1,0,0,0,0,0,0,0,1));
    drv(1,1,0,0,0,0, E(1,0,0,0,0,1,0,0,2));
    drv(1,1,1,0,0,0, E(1,0,0,0,1,0,0,0,2));
    // Resync timeout, max 4, saturation, reset beating increment
    drv(0,1,0,0,0,0, E(1,0,0,0,0,0,1,0,3));
    drv(1,1,1,0,0,0, E(1,0,0,0,0,0,1,0,3));
    drv(1,1,1,0,0,0, E(1,0,0,0,0,0,0,1,4));
    drv(1,1,1,0,0,0, E(1,0,0,0,0,0,0,1,4));
    drv(1,1,1,1,0,0, E(1,0,0,0,0,0,0,1,4));
    drv(0,1,0,0,0,0, E(1,0,0,0,0,0,0,0,0));
    // Packet mode, zero threshold treated as 1
    r_mode = 1'b1; r_max = 16'd0;
    drv(0,1,0,0,0,0, E(1,0,0,0,0,0,1,0,0));
    drv(0,1,0,0,1,0, E(1,0,0,0,0,0,1,0,0));
    drv(0,1,0,0,0,0, E(1,0,0,0,0,0,0,1,1));
    drv(1,1,0,0,1,0, E(1,0,0,0,0,1,0,1,1));
    drv(0,1,0,1,0,0, E(1,0,0,0,0,0,0,1,1));
    drv(0,1,0,0,0,0, E(1,0,0,0,0,0,1,0,0));
    // Opmode changes collapse into one event
    r_mode = 1'b0; r_max = 16'd4;
    drv(0,1,0,0,0,1, E(1,0,0,0,0,0,0,0,0));
    drv(0,1,0,0,0,2, E(1,0,0,0,0,0,0,0,0));
    drv(1,1,0,0,0,2, E(1,0,0,1,0,0,0,0,0));
    drv(1,1,0,0,0,2, E(1,0,0,0,0,0,0,0,0));
    // Disable with last instruction qualified
    drv(1,1,1,0,0,2, E(1,0,0,0,1,0,0,0,0));
    drv(0,0,0,0,0,2, E(1,0,0,0,0,0,0,0,1));
    drv(0,0,0,0,0,2, E(0,0,0,0,0,0,0,0,0));
    drv(1,0,0,0,0,2, E(0,0,1,0,0,1,0,0,0));
    drv(0,0,0,0,0,2, E(0,0,0,0,0,0,0,0,0));
    // Re-enable, disable, then asynchronous reset in STOPPING
    drv(0,1,0,0,0,2, E(0,0,0,0,0,0,0,0,0));
    drv(1,1,0,0,0,2, E(0,1,0,0,0,0,0,0,0));
    drv(1,1,1,0,0,2, E(1,0,0,0,1,0,0,0,0));
    drv(0,0,0,0,0,2, E(1,0,0,0,0,0,0,0,1));
    drv(0,0,0,0,0,2, E(0,0,0,0,0,0,0,0,0));
    r_rst = 1'b1;
    drv(1,0,0,0,0,2, E(0,0,0,0,0,0,0,0,0));
    r_rst = 1'b0;
    drv(1,0,0,0,0,2, E(0,0,0,0,0,0,0,0,0));
    drv(1,0,0,0,0,2, E(0,0,0,0,0,0,0,0,0));

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_i);
    #1;
    if (exp_q.size() > 0) begin
      nerr++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
